// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nibble_serial_adder_pkg : shared types and constants for the adder    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package nibble_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NIBBLE_W = 4;

    // Index register must stay at least one bit wide even for a single nibble.
    function automatic int unsigned idx_width(input int unsigned nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/CLA_4bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | CLA_4bit : 4-bit carry-lookahead adder slice with group P/G outputs   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module CLA_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       p,
    output logic       g,
    output logic       cout
);

    logic [3:0] w_gen;
    logic [3:0] w_prop;
    logic [3:0] w_carry;

    assign w_gen  = a & b;
    assign w_prop = a ^ b;

    assign w_carry[0] = cin;
    assign w_carry[1] = w_gen[0] | (w_prop[0] & cin);
    assign w_carry[2] = w_gen[1] | (w_prop[1] & w_gen[0]) | (w_prop[1] & w_prop[0] & cin);
    assign w_carry[3] = w_gen[2] | (w_prop[2] & w_gen[1]) | (w_prop[2] & w_prop[1] & w_gen[0])
                      | (w_prop[2] & w_prop[1] & w_prop[0] & cin);

    assign s    = w_prop ^ w_carry;
    assign p    = &w_prop;
    assign g    = w_gen[3] | (w_prop[3] & w_gen[2]) | (w_prop[3] & w_prop[2] & w_gen[1])
                | (w_prop[3] & w_prop[2] & w_prop[1] & w_gen[0]);
    assign cout = g | (p & cin);

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nibble_serial_adder : digit-serial adder, one nibble per clock        |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W   = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic [WIDTH-1:0]   sum_d;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic               cout_q;
    logic               ovf_q;
    logic               zero_q;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [3:0]         slice_s;
    logic               slice_cout;
    logic               unused_p;
    logic               unused_g;

    CLA_4bit u_slice (
        .a    (a_q[3:0]),
        .b    (b_q[3:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .p    (unused_p),
        .g    (unused_g),
        .cout (slice_cout)
    );

    // New nibble enters at the top so the first one ends up at bits 3:0.
    generate
        if (NIBBLES == 1) begin : g_shift_single
            assign sum_d = slice_s;
        end else begin : g_shift_multi
            assign sum_d = {slice_s, sum_q[WIDTH-1:NIBBLE_W]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    a_q     <= a_q >> NIBBLE_W;
                    b_q     <= b_q >> NIBBLE_W;
                    sum_q   <= sum_d;
                    carry_q <= slice_cout;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= slice_cout;
                        // Carry into the MSB is recovered from that bit's half-sum.
                        ovf_q       <= (a_q[3] ^ b_q[3] ^ slice_s[3]) ^ slice_cout;
                        zero_q      <= (sum_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nibble_serial_adder : randomized + directed bench for the adder    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    // ---------------- behavioural model: handshake timing + arithmetic result
    bit               started = 0;
    bit               m_rdy = 1, m_vld = 0, m_busy = 0;
    int               m_cnt = 0;
    int               m_handshakes = 0;
    logic [WIDTH-1:0] m_sum = '0, p_sum = '0;
    bit               m_cout = 0, m_ovf = 0, m_zero = 0;
    bit               p_cout = 0, p_ovf = 0;
    logic [WIDTH:0]   t;

    always @(posedge clk) begin
        started = 1;
        if (rst) begin
            m_rdy = 1; m_vld = 0; m_busy = 0;
            m_sum = '0; m_cout = 0; m_ovf = 0; m_zero = 0;
        end else if (m_rdy) begin
            if (in_valid) begin
                t      = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
                p_sum  = t[WIDTH-1:0];
                p_cout = t[WIDTH];
                p_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
                m_rdy  = 0; m_busy = 1; m_cnt = NIB;
            end
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy = 0; m_vld = 1;
                m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf; m_zero = (p_sum == 0);
            end
        end else if (m_vld && out_ready) begin
            m_vld = 0; m_rdy = 1; m_handshakes++;
        end
    end

    // Expected sums in issue order, built independently from each accepted pair.
    logic [WIDTH-1:0] sent[$];

    always @(negedge clk) begin
        if (started) begin
            check("in_ready", in_ready, m_rdy);
            check("out_valid", out_valid, m_vld);
            if (!m_busy) begin
                check("sum", sum, m_sum);
                check("cout", cout, m_cout);
                check("ovf", ovf, m_ovf);
                check("zero", zero, m_zero);
            end
            if (out_valid && out_ready && !rst) begin
                if (sent.size() == 0) check("unexpected_result", 1, 0);
                else check("order_sum", sum, sent.pop_front());
            end
        end
    end

    // ---------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic cv, input bit keep);
        int  k   = 0;
        bit  acc = 0;
        logic [WIDTH:0] r;
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        while (!acc && k < 40) begin
            acc = in_ready;
            tick();
            k++;
        end
        if (!acc) check("accept_timeout", 0, 1);
        if (!keep) in_valid = 1'b0;
        r = {1'b0, av} + {1'b0, bv} + (WIDTH+1)'(cv);
        if (acc) sent.push_back(r[WIDTH-1:0]);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        if (!out_valid) check("result_timeout", 0, 1);
    endtask

    task automatic dir_op(input string nm, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv, input logic [WIDTH-1:0] es, input bit ec,
                          input bit eo, input bit ez, input int hold);
        int n;
        out_ready = (hold == 0);
        send(av, bv, cv, 0);
        wait_valid(n);
        check({nm, "_latency"}, n, NIB);
        check({nm, "_sum"}, sum, es);
        check({nm, "_cout"}, cout, ec);
        check({nm, "_ovf"}, ovf, eo);
        check({nm, "_zero"}, zero, ez);
        if (hold > 0) begin
            repeat (hold) tick();
            check({nm, "_held_sum"}, sum, es);
            check({nm, "_held_valid"}, out_valid, 1);
            check({nm, "_held_ready"}, in_ready, 0);
            out_ready = 1'b1;
        end
        tick();
        check({nm, "_drop_valid"}, out_valid, 0);
        check({nm, "_back_ready"}, in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hs0;
        int k;
        int n;
        logic [WIDTH-1:0] edges [6] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001, 16'hAAAA};
        logic [WIDTH-1:0] ra, rb;

        repeat (3) tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_flags", {cout, ovf, zero}, 3'b000);
        rst = 1'b0;
        tick();

        dir_op("p5555", 16'h1234, 16'h4321, 1'b0, 16'h5555, 0, 0, 0, 0);
        dir_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1, 0, 1, 0);
        dir_op("posovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 0, 1, 0, 0);
        dir_op("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1, 1, 1, 0);
        dir_op("cinhold", 16'h0000, 16'h0000, 1'b1, 16'h0001, 0, 0, 0, 3);

        // Abort an operation on its second BUSY edge.
        send(16'h5A5A, 16'h1234, 1'b0, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sent.pop_back());
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_flags", {cout, ovf, zero}, 3'b000);
        repeat (6) tick();
        check("abort_no_result", out_valid, 0);
        dir_op("abcd", 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 0, 0, 0, 0);

        // Back-to-back with in_valid held high across three pairs.
        out_ready = 1'b1;
        hs0 = m_handshakes;
        send(16'h0F0F, 16'h00F1, 1'b0, 1);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1);
        send(16'h1357, 16'h2468, 1'b0, 1);
        in_valid = 1'b0;
        k = 0;
        while (m_handshakes - hs0 < 3 && k < 100) begin
            tick();
            k++;
        end
        check("b2b_count", m_handshakes - hs0, 3);

        // Randomized operations with random consumer back-pressure.
        for (int i = 0; i < 60; i++) begin
            ra = ($urandom_range(3) == 0) ? edges[$urandom_range(5)] : WIDTH'($urandom);
            rb = ($urandom_range(3) == 0) ? edges[$urandom_range(5)] : WIDTH'($urandom);
            repeat ($urandom_range(2)) tick();
            out_ready = 1'($urandom_range(1));
            send(ra, rb, 1'($urandom_range(1)), 0);
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            cin = 1'($urandom_range(1));
            wait_valid(n);
            out_ready = 1'b0;
            repeat ($urandom_range(2)) tick();
            out_ready = 1'b1;
            tick();
        end

        repeat (4) tick();
        check("sent_drained", sent.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
